// File: rtl/alu_pkg.sv
// alu_pkg: ALU operation codes, MIPS opcode/funct constants and operand-select
// types shared by the ID/EX decode and pipeline register.
package alu_pkg;
    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SLL  = 4'b0011,
        ALU_SRL  = 4'b0100,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_ADDU = 4'b1000,
        ALU_SUBU = 4'b1001,
        ALU_XOR  = 4'b1010,
        ALU_SLTU = 4'b1011,
        ALU_NOR  = 4'b1100,
        ALU_SRA  = 4'b1101,
        ALU_LUI  = 4'b1110
    } alu_op_e;

    typedef enum logic [1:0] {A_RS, A_RT, A_ZERO} a_sel_e;
    typedef enum logic [1:0] {B_RT, B_IMM, B_SHAMT} b_sel_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;
endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID-side inputs, forwarding sources and EX-side outputs of the
// ID/EX stage; slave is the stage itself, master is whoever drives it.
interface id_ex_stage_if;
    logic        InValid;
    logic        Stall;
    logic        Flush;
    logic [31:0] Instr;
    logic [31:0] RsData;
    logic [31:0] RtData;
    logic        ExMemRegWrite;
    logic [4:0]  ExMemRd;
    logic [31:0] ExMemResult;
    logic        MemWbRegWrite;
    logic [4:0]  MemWbRd;
    logic [31:0] MemWbData;
    logic [31:0] BusA;
    logic [31:0] BusB;
    logic [3:0]  ALUCtrl;
    logic        OutValid;
    logic [4:0]  OutRd;
    logic        OutRegWrite;
    logic        OutMemRead;
    logic        LoadUseHazard;

    modport master (
        output InValid, Stall, Flush, Instr, RsData, RtData,
               ExMemRegWrite, ExMemRd, ExMemResult, MemWbRegWrite, MemWbRd, MemWbData,
        input  BusA, BusB, ALUCtrl, OutValid, OutRd, OutRegWrite, OutMemRead, LoadUseHazard
    );

    modport slave (
        input  InValid, Stall, Flush, Instr, RsData, RtData,
               ExMemRegWrite, ExMemRd, ExMemResult, MemWbRegWrite, MemWbRd, MemWbData,
        output BusA, BusB, ALUCtrl, OutValid, OutRd, OutRegWrite, OutMemRead, LoadUseHazard
    );
endinterface

// File: rtl/alu_decode.sv
// alu_decode: combinational MIPS decode of ALU op, immediate, destination,
// write/load flags and operand selects.
module alu_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output alu_op_e     alu_ctrl,
    output logic [31:0] imm,
    output logic [4:0]  dest,
    output logic        reg_write,
    output logic        mem_read,
    output a_sel_e      a_sel,
    output b_sel_e      b_sel,
    output logic [4:0]  a_idx,
    output logic [4:0]  b_idx
);
    logic [5:0] op;
    logic [5:0] fn;
    logic       zext;
    logic       shift;

    assign op    = instr[31:26];
    assign fn    = instr[5:0];
    assign zext  = op == OP_ANDI || op == OP_ORI || op == OP_XORI;
    assign shift = op == OP_RTYPE && (fn == FN_SLL || fn == FN_SRL || fn == FN_SRA);
    assign imm   = zext ? {16'd0, instr[15:0]} : {{16{instr[15]}}, instr[15:0]};
    assign dest  = op == OP_RTYPE ? instr[15:11] : instr[20:16];
    assign mem_read = op == OP_LW;
    assign a_sel = shift ? A_RT : op == OP_LUI ? A_ZERO : A_RS;
    assign b_sel = shift ? B_SHAMT : op == OP_RTYPE ? B_RT : B_IMM;
    assign a_idx = shift ? instr[20:16] : instr[25:21];
    assign b_idx = instr[20:16];

    // Unknown opcodes and functs fall back to a harmless non-writing AND.
    always_comb begin
        alu_ctrl  = ALU_AND;
        reg_write = 1'b1;
        if (op == OP_RTYPE)
            case (fn)
                FN_ADD:  alu_ctrl = ALU_ADD;
                FN_ADDU: alu_ctrl = ALU_ADDU;
                FN_SUB:  alu_ctrl = ALU_SUB;
                FN_SUBU: alu_ctrl = ALU_SUBU;
                FN_AND:  alu_ctrl = ALU_AND;
                FN_OR:   alu_ctrl = ALU_OR;
                FN_XOR:  alu_ctrl = ALU_XOR;
                FN_NOR:  alu_ctrl = ALU_NOR;
                FN_SLT:  alu_ctrl = ALU_SLT;
                FN_SLTU: alu_ctrl = ALU_SLTU;
                FN_SLL:  alu_ctrl = ALU_SLL;
                FN_SRL:  alu_ctrl = ALU_SRL;
                FN_SRA:  alu_ctrl = ALU_SRA;
                default: reg_write = 1'b0;
            endcase
        else
            case (op)
                OP_ADDI, OP_LW: alu_ctrl = ALU_ADD;
                OP_ADDIU:       alu_ctrl = ALU_ADDU;
                OP_SLTI:        alu_ctrl = ALU_SLT;
                OP_SLTIU:       alu_ctrl = ALU_SLTU;
                OP_ANDI:        alu_ctrl = ALU_AND;
                OP_ORI:         alu_ctrl = ALU_OR;
                OP_XORI:        alu_ctrl = ALU_XOR;
                OP_LUI:         alu_ctrl = ALU_LUI;
                OP_SW: begin
                    alu_ctrl  = ALU_ADD;
                    reg_write = 1'b0;
                end
                OP_BEQ, OP_BNE: begin
                    alu_ctrl  = ALU_SUB;
                    reg_write = 1'b0;
                end
                default: reg_write = 1'b0;
            endcase
    end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with ALU decode and load-use detection.
// Define ID_EX_FWD_EN to forward EX/MEM and MEM/WB results onto BusA/BusB.
module id_ex_stage
    import alu_pkg::*;
(
    input logic          CLK,
    input logic          ResetL,
    id_ex_stage_if.slave bus
);
    alu_op_e     dec_ctrl;
    logic [31:0] dec_imm;
    logic [4:0]  dec_dest;
    logic        dec_rw;
    logic        dec_mr;
    a_sel_e      dec_a;
    b_sel_e      dec_b;
    logic [4:0]  dec_a_idx;
    logic [4:0]  dec_b_idx;

    logic        valid;
    logic        reg_write;
    logic        mem_read;
    logic [4:0]  rd;
    logic [3:0]  alu_ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  a_idx;
    logic [4:0]  b_idx;
    logic        a_fwd;
    logic        b_fwd;

    alu_decode u_dec (
        .instr     (bus.Instr),
        .alu_ctrl  (dec_ctrl),
        .imm       (dec_imm),
        .dest      (dec_dest),
        .reg_write (dec_rw),
        .mem_read  (dec_mr),
        .a_sel     (dec_a),
        .b_sel     (dec_b),
        .a_idx     (dec_a_idx),
        .b_idx     (dec_b_idx)
    );

    always_ff @(posedge CLK or negedge ResetL) begin
        if (!ResetL) begin
            valid     <= 1'b0;
            reg_write <= 1'b0;
            mem_read  <= 1'b0;
            rd        <= 5'd0;
            alu_ctrl  <= 4'd0;
            op_a      <= 32'd0;
            op_b      <= 32'd0;
            a_idx     <= 5'd0;
            b_idx     <= 5'd0;
            a_fwd     <= 1'b0;
            b_fwd     <= 1'b0;
        end else if (bus.Flush) begin
            valid     <= 1'b0;
            reg_write <= 1'b0;
            mem_read  <= 1'b0;
        end else if (!bus.Stall) begin
            valid     <= bus.InValid;
            reg_write <= bus.InValid && dec_rw && dec_dest != 5'd0;
            mem_read  <= bus.InValid && dec_mr;
            rd        <= dec_dest;
            alu_ctrl  <= dec_ctrl;
            op_a      <= dec_a == A_RS ? bus.RsData : dec_a == A_RT ? bus.RtData : 32'd0;
            op_b      <= dec_b == B_RT ? bus.RtData : dec_b == B_SHAMT ? {27'd0, dec_imm[10:6]} : dec_imm;
            a_idx     <= dec_a_idx;
            b_idx     <= dec_b_idx;
            a_fwd     <= dec_a != A_ZERO;
            b_fwd     <= dec_b == B_RT;
        end
    end

`ifdef ID_EX_FWD_EN
    logic ex_a, wb_a, ex_b, wb_b;
    assign ex_a = a_fwd && bus.ExMemRegWrite && bus.ExMemRd != 5'd0 && bus.ExMemRd == a_idx;
    assign wb_a = a_fwd && bus.MemWbRegWrite && bus.MemWbRd != 5'd0 && bus.MemWbRd == a_idx;
    assign ex_b = b_fwd && bus.ExMemRegWrite && bus.ExMemRd != 5'd0 && bus.ExMemRd == b_idx;
    assign wb_b = b_fwd && bus.MemWbRegWrite && bus.MemWbRd != 5'd0 && bus.MemWbRd == b_idx;
    assign bus.BusA = ex_a ? bus.ExMemResult : wb_a ? bus.MemWbData : op_a;
    assign bus.BusB = ex_b ? bus.ExMemResult : wb_b ? bus.MemWbData : op_b;
`else
    logic unused_fwd;
    assign unused_fwd = ^{bus.ExMemRegWrite, bus.ExMemRd, bus.ExMemResult, bus.MemWbRegWrite,
                          bus.MemWbRd, bus.MemWbData, a_idx, b_idx, a_fwd, b_fwd};
    assign bus.BusA = op_a;
    assign bus.BusB = op_b;
`endif

    assign bus.ALUCtrl       = alu_ctrl;
    assign bus.OutValid      = valid;
    assign bus.OutRd         = rd;
    assign bus.OutRegWrite   = reg_write;
    assign bus.OutMemRead    = mem_read;
    assign bus.LoadUseHazard = valid && mem_read && rd != 5'd0 && bus.InValid &&
                               (rd == bus.Instr[25:21] || rd == bus.Instr[20:16]);
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and randomized checks of id_ex_stage against a
// table-driven instruction model; honours ID_EX_FWD_EN like the design.
module tb_id_ex_stage;
    logic CLK = 1'b0;
    logic ResetL = 1'b1;
    int   errors = 0;
    int   checks = 0;

`ifdef ID_EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    id_ex_stage_if bus ();
    id_ex_stage dut (.CLK(CLK), .ResetL(ResetL), .bus(bus));

    always #5 CLK = ~CLK;

    typedef struct {
        logic        v, rw, mr;
        logic [4:0]  rd;
        logic [3:0]  ctrl;
        logic [31:0] a, b;
        int          asrc, bsrc;
    } st_t;
    st_t exp;

    logic [5:0] r_fn [13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};
    logic [3:0] r_ct [13] = '{4'b0010, 4'b1000, 4'b0110, 4'b1001, 4'b0000, 4'b0001, 4'b1010, 4'b1100,
                             4'b0111, 4'b1011, 4'b0011, 4'b0100, 4'b1101};
    logic [5:0] i_op [12] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05};
    logic [3:0] i_ct [12] = '{4'b0010, 4'b1000, 4'b0111, 4'b1011, 4'b0000, 4'b0001, 4'b1010, 4'b1110,
                             4'b0010, 4'b0010, 4'b0110, 4'b0110};
    logic       i_rw [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    // What the EX stage should hold after loading instruction i; asrc/bsrc name
    // the source register of a forwardable operand, -1 for immediates/constants.
    function automatic st_t mdl(logic [31:0] i, logic [31:0] rs, logic [31:0] rt, logic iv);
        st_t m;
        logic [5:0] op;
        logic [5:0] fn;
        op = i[31:26];
        fn = i[5:0];
        m.ctrl = 4'b0000;
        m.rw = 1'b0;
        m.mr = op == 6'h23;
        m.rd = op == 6'h00 ? i[15:11] : i[20:16];
        m.a = rs;
        m.asrc = int'(i[25:21]);
        m.b = (op == 6'h0C || op == 6'h0D || op == 6'h0E) ? {16'h0, i[15:0]} : {{16{i[15]}}, i[15:0]};
        m.bsrc = -1;
        if (op == 6'h00) begin
            m.b = rt;
            m.bsrc = int'(i[20:16]);
            foreach (r_fn[k]) if (fn == r_fn[k]) begin m.ctrl = r_ct[k]; m.rw = 1'b1; end
            if (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) begin
                m.a = rt;
                m.asrc = int'(i[20:16]);
                m.b = {27'd0, i[10:6]};
                m.bsrc = -1;
            end
        end else begin
            foreach (i_op[k]) if (op == i_op[k]) begin m.ctrl = i_ct[k]; m.rw = i_rw[k]; end
            if (op == 6'h0F) begin m.a = 32'd0; m.asrc = -1; end
        end
        m.v = iv;
        m.rw = m.rw && iv && m.rd != 5'd0;
        m.mr = m.mr && iv;
        return m;
    endfunction

    function automatic logic [31:0] fw(int src, logic [31:0] v);
`ifdef ID_EX_FWD_EN
        if (src > 0 && bus.ExMemRegWrite && int'(bus.ExMemRd) == src) return bus.ExMemResult;
        if (src > 0 && bus.MemWbRegWrite && int'(bus.MemWbRd) == src) return bus.MemWbData;
`endif
        return v;
    endfunction

    task automatic model_reset();
        exp = '{default: 0};
        exp.asrc = -1;
        exp.bsrc = -1;
    endtask

    task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] er,
                           input logic ww, input logic [4:0] wrd, input logic [31:0] wd);
        bus.ExMemRegWrite = ew;
        bus.ExMemRd = erd;
        bus.ExMemResult = er;
        bus.MemWbRegWrite = ww;
        bus.MemWbRd = wrd;
        bus.MemWbData = wd;
    endtask

    task automatic step(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt,
                        input logic iv, input logic st, input logic fl);
        bus.Instr = i;
        bus.RsData = rs;
        bus.RtData = rt;
        bus.InValid = iv;
        bus.Stall = st;
        bus.Flush = fl;
        @(posedge CLK);
        if (fl) begin
            exp.v = 1'b0;
            exp.rw = 1'b0;
            exp.mr = 1'b0;
        end else if (!st) exp = mdl(i, rs, rt, iv);
        #1;
    endtask

    task automatic test_reset();
        step(32'h00221820, 32'h11, 32'h22, 1'b1, 1'b0, 1'b0);
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #2 ResetL = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({bus.OutValid, bus.OutRegWrite, bus.OutMemRead, bus.OutRd, bus.ALUCtrl, bus.BusA, bus.BusB} !== 76'd0)
            begin errors++; $display("FAIL reset_state got=%h want=0", {bus.OutValid, bus.OutRegWrite, bus.OutMemRead, bus.OutRd, bus.ALUCtrl, bus.BusA, bus.BusB}); end
        checks++;
        if (bus.LoadUseHazard !== 1'b0)
            begin errors++; $display("FAIL reset_hazard got=%b want=0", bus.LoadUseHazard); end
        @(negedge CLK);
        ResetL = 1'b1;
    endtask

    task automatic test_decode();
        step(32'h00221820, 32'd5, 32'd7, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({bus.BusA, bus.BusB, bus.ALUCtrl, bus.OutRd, bus.OutRegWrite, bus.OutValid} !== {32'd5, 32'd7, 4'b0010, 5'd3, 1'b1, 1'b1})
            begin errors++; $display("FAIL add got=%h want=%h", {bus.BusA, bus.BusB, bus.ALUCtrl, bus.OutRd, bus.OutRegWrite, bus.OutValid}, {32'd5, 32'd7, 4'b0010, 5'd3, 1'b1, 1'b1}); end
        step(32'h3024FFFF, 32'd9, 32'd1, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({bus.BusA, bus.BusB, bus.ALUCtrl, bus.OutRd} !== {32'd9, 32'h0000FFFF, 4'b0000, 5'd4})
            begin errors++; $display("FAIL andi got=%h want=%h", {bus.BusA, bus.BusB, bus.ALUCtrl, bus.OutRd}, {32'd9, 32'h0000FFFF, 4'b0000, 5'd4}); end
        step(32'h2024FFFF, 32'd9, 32'd1, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({bus.BusB, bus.ALUCtrl, bus.OutRegWrite} !== {32'hFFFFFFFF, 4'b0010, 1'b1})
            begin errors++; $display("FAIL addi got=%h want=%h", {bus.BusB, bus.ALUCtrl, bus.OutRegWrite}, {32'hFFFFFFFF, 4'b0010, 1'b1}); end
        step(32'h00031100, 32'hDEAD, 32'd1, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({bus.BusA, bus.BusB, bus.ALUCtrl, bus.OutRd} !== {32'd1, 32'd4, 4'b0011, 5'd2})
            begin errors++; $display("FAIL sll got=%h want=%h", {bus.BusA, bus.BusB, bus.ALUCtrl, bus.OutRd}, {32'd1, 32'd4, 4'b0011, 5'd2}); end
        step(32'h3C051234, 32'hBEEF, 32'h77, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({bus.BusA, bus.BusB, bus.ALUCtrl, bus.OutRd, bus.OutRegWrite} !== {32'd0, 32'h1234, 4'b1110, 5'd5, 1'b1})
            begin errors++; $display("FAIL lui got=%h want=%h", {bus.BusA, bus.BusB, bus.ALUCtrl, bus.OutRd, bus.OutRegWrite}, {32'd0, 32'h1234, 4'b1110, 5'd5, 1'b1}); end
        step(32'hAC220004, 32'd8, 32'd3, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({bus.BusB, bus.ALUCtrl, bus.OutRegWrite, bus.OutMemRead} !== {32'd4, 4'b0010, 1'b0, 1'b0})
            begin errors++; $display("FAIL sw got=%h want=%h", {bus.BusB, bus.ALUCtrl, bus.OutRegWrite, bus.OutMemRead}, {32'd4, 4'b0010, 1'b0, 1'b0}); end
        step(32'h8C280010, 32'd8, 32'd3, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({bus.OutRd, bus.ALUCtrl, bus.OutRegWrite, bus.OutMemRead} !== {5'd8, 4'b0010, 1'b1, 1'b1})
            begin errors++; $display("FAIL lw got=%h want=%h", {bus.OutRd, bus.ALUCtrl, bus.OutRegWrite, bus.OutMemRead}, {5'd8, 4'b0010, 1'b1, 1'b1}); end
        step(32'hFC221826, 32'd1, 32'd2, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({bus.ALUCtrl, bus.OutRegWrite, bus.OutMemRead} !== {4'b0000, 1'b0, 1'b0})
            begin errors++; $display("FAIL illegal_op got=%h want=%h", {bus.ALUCtrl, bus.OutRegWrite, bus.OutMemRead}, {4'b0000, 1'b0, 1'b0}); end
        step(32'h00220020, 32'd1, 32'd2, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({bus.OutRd, bus.OutRegWrite, bus.OutValid} !== {5'd0, 1'b0, 1'b1})
            begin errors++; $display("FAIL rd_zero got=%h want=%h", {bus.OutRd, bus.OutRegWrite, bus.OutValid}, {5'd0, 1'b0, 1'b1}); end
        step(32'h00221820, 32'd5, 32'd7, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({bus.OutValid, bus.OutRegWrite} !== 2'b00)
            begin errors++; $display("FAIL invalid_in got=%b want=00", {bus.OutValid, bus.OutRegWrite}); end
    endtask

    task automatic test_forward();
        step(32'h00221820, 32'd5, 32'd7, 1'b1, 1'b0, 1'b0);
        set_fwd(1'b1, 5'd1, 32'hAA, 1'b1, 5'd1, 32'hBB);
        #1;
        checks++;
        if (bus.BusA !== (FWD ? 32'hAA : 32'd5))
            begin errors++; $display("FAIL fwd_exmem got=%h want=%h", bus.BusA, FWD ? 32'hAA : 32'd5); end
        checks++;
        if (bus.BusB !== 32'd7)
            begin errors++; $display("FAIL fwd_nomatch got=%h want=7", bus.BusB); end
        bus.ExMemRd = 5'd0;
        #1;
        checks++;
        if (bus.BusA !== (FWD ? 32'hBB : 32'd5))
            begin errors++; $display("FAIL fwd_memwb got=%h want=%h", bus.BusA, FWD ? 32'hBB : 32'd5); end
        set_fwd(1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB);
        #1;
        checks++;
        if (bus.BusA !== 32'd5)
            begin errors++; $display("FAIL fwd_r0 got=%h want=5", bus.BusA); end
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        step(32'h2024FFFF, 32'd9, 32'd1, 1'b1, 1'b0, 1'b0);
        set_fwd(1'b1, 5'd4, 32'hAA, 1'b1, 5'd4, 32'hBB);
        #1;
        checks++;
        if (bus.BusB !== 32'hFFFFFFFF)
            begin errors++; $display("FAIL fwd_imm got=%h want=ffffffff", bus.BusB); end
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_stall_flush();
        step(32'h00221820, 32'd5, 32'd7, 1'b1, 1'b0, 1'b0);
        step(32'h3024FFFF, 32'd9, 32'd9, 1'b1, 1'b1, 1'b1);
        checks++;
        if ({bus.OutValid, bus.OutRegWrite, bus.OutMemRead} !== 3'b000)
            begin errors++; $display("FAIL flush_over_stall got=%b want=000", {bus.OutValid, bus.OutRegWrite, bus.OutMemRead}); end
        step(32'h00221820, 32'd5, 32'd7, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(32'h3C051234, 32'd1, 32'd2, 1'b1, 1'b1, 1'b0);
            checks++;
            if ({bus.OutValid, bus.OutRegWrite, bus.OutMemRead, bus.OutRd, bus.ALUCtrl, bus.BusA, bus.BusB} !==
                {1'b1, 1'b1, 1'b0, 5'd3, 4'b0010, 32'd5, 32'd7})
                begin errors++; $display("FAIL stall_hold[%0d] got=%h want=%h", k, {bus.OutValid, bus.OutRegWrite, bus.OutMemRead, bus.OutRd, bus.ALUCtrl, bus.BusA, bus.BusB}, {1'b1, 1'b1, 1'b0, 5'd3, 4'b0010, 32'd5, 32'd7}); end
        end
        #3 ResetL = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({bus.OutValid, bus.OutRegWrite, bus.ALUCtrl} !== 6'd0)
            begin errors++; $display("FAIL reset_mid_stall got=%b want=0", {bus.OutValid, bus.OutRegWrite, bus.ALUCtrl}); end
        @(negedge CLK);
        ResetL = 1'b1;
        step(32'h00221820, 32'd5, 32'd7, 1'b1, 1'b1, 1'b0);
        checks++;
        if (bus.OutValid !== 1'b0)
            begin errors++; $display("FAIL stall_after_reset got=%b want=0", bus.OutValid); end
    endtask

    task automatic test_hazard();
        step(32'h8C080000, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        bus.Instr = 32'h01014820;
        bus.InValid = 1'b1;
        #1;
        checks++;
        if (bus.LoadUseHazard !== 1'b1)
            begin errors++; $display("FAIL load_use got=%b want=1", bus.LoadUseHazard); end
        bus.InValid = 1'b0;
        #1;
        checks++;
        if (bus.LoadUseHazard !== 1'b0)
            begin errors++; $display("FAIL load_use_idle got=%b want=0", bus.LoadUseHazard); end
        step(32'h8C000000, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        bus.Instr = 32'h00004820;
        bus.InValid = 1'b1;
        #1;
        checks++;
        if (bus.LoadUseHazard !== 1'b0)
            begin errors++; $display("FAIL load_use_r0 got=%b want=0", bus.LoadUseHazard); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ins;
            logic        hz;
            ins = $urandom;
            ins[25:21] = 5'($urandom_range(0, 3));
            ins[20:16] = 5'($urandom_range(0, 3));
            ins[15:11] = 5'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: begin ins[31:26] = 6'h00; ins[5:0] = r_fn[$urandom_range(0, 12)]; end
                1: ins[31:26] = i_op[$urandom_range(0, 11)];
                2: ins[31:26] = 6'h00;
                default: ;
            endcase
            step(ins, $urandom, $urandom, $urandom_range(0, 7) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
            set_fwd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
            #1;
            hz = exp.v && exp.mr && exp.rd != 5'd0 && bus.InValid &&
                 (exp.rd == bus.Instr[25:21] || exp.rd == bus.Instr[20:16]);
            checks++;
            if ({bus.OutValid, bus.OutRegWrite, bus.OutMemRead, bus.OutRd, bus.ALUCtrl} !== {exp.v, exp.rw, exp.mr, exp.rd, exp.ctrl})
                begin errors++; $display("FAIL rnd_ctrl[%0d] got=%h want=%h", n, {bus.OutValid, bus.OutRegWrite, bus.OutMemRead, bus.OutRd, bus.ALUCtrl}, {exp.v, exp.rw, exp.mr, exp.rd, exp.ctrl}); end
            checks++;
            if (bus.BusA !== fw(exp.asrc, exp.a))
                begin errors++; $display("FAIL rnd_busa[%0d] got=%h want=%h", n, bus.BusA, fw(exp.asrc, exp.a)); end
            checks++;
            if (bus.BusB !== fw(exp.bsrc, exp.b))
                begin errors++; $display("FAIL rnd_busb[%0d] got=%h want=%h", n, bus.BusB, fw(exp.bsrc, exp.b)); end
            checks++;
            if (bus.LoadUseHazard !== hz)
                begin errors++; $display("FAIL rnd_hazard[%0d] got=%b want=%b", n, bus.LoadUseHazard, hz); end
        end
    endtask

    initial begin
        bus.Instr = 32'd0;
        bus.RsData = 32'd0;
        bus.RtData = 32'd0;
        bus.InValid = 1'b0;
        bus.Stall = 1'b0;
        bus.Flush = 1'b0;
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        model_reset();
        test_reset();
        test_decode();
        test_forward();
        test_stall_flush();
        test_hazard();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL use one clock, CLK; reset ResetL is asynchronous and active-low.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 ResetL  input  1  asynchronous active-low reset.
REQ-004 InValid  input  1  ID stage holds a valid instruction.
REQ-005 Stall  input  1  hold stage contents this cycle.
REQ-006 Flush  input  1  replace stage contents with a bubble.
REQ-007 Instr  input  32  MIPS instruction word from ID.
REQ-008 RsData  input  32  register-file read of Instr[25:21].
REQ-009 RtData  input  32  register-file read of Instr[20:16].
REQ-010 ExMemRegWrite  input  1  EX/MEM instruction writes a register.
REQ-011 ExMemRd  input  5  EX/MEM destination register.
REQ-012 ExMemResult  input  32  EX/MEM ALU result.
REQ-013 MemWbRegWrite  input  1  MEM/WB instruction writes a register.
REQ-014 MemWbRd  input  5  MEM/WB destination register.
REQ-015 MemWbData  input  32  MEM/WB write-back data.
REQ-016 BusA  output  32  ALU operand A.
REQ-017 BusB  output  32  ALU operand B.
REQ-018 ALUCtrl  output  4  ALU operation code.
REQ-019 OutValid  output  1  EX stage holds a valid instruction.
REQ-020 OutRd  output  5  EX destination register.
REQ-021 OutRegWrite  output  1  EX instruction writes a register (forced 0 when OutRd==0 or OutValid==0).
REQ-022 OutMemRead  output  1  EX instruction is lw.
REQ-023 LoadUseHazard  output  1  combinational: OutValid & OutMemRead & OutRd!=0 & (OutRd==Instr[25:21] | OutRd==Instr[20:16]) & InValid.

Function
REQ-024 Rising CLK priority SHALL be Flush > Stall > load; Flush clears OutValid, OutRegWrite, OutMemRead; Stall holds every register; load captures decoded InValid-qualified fields.
REQ-025 Latency SHALL be one cycle: fields decoded in cycle N appear on outputs in N+1; BusA/BusB forwarding muxes SHALL be combinational from registered fields.
REQ-026 ALUCtrl decode, R-type (opcode 0) funct: 20 ADD 0010, 21 ADDU 1000, 22 SUB 0110, 23 SUBU 1001, 24 AND 0000, 25 OR 0001, 26 XOR 1010, 27 NOR 1100, 2A SLT 0111, 2B SLTU 1011, 00 SLL 0011, 02 SRL 0100, 03 SRA 1101 (hex).
REQ-027 I-type opcode: 08 ADD, 09 ADDU, 0A SLT, 0B SLTU, 0C AND, 0D OR, 0E XOR, 0F LUI 1110, 23 lw ADD, 2B sw ADD, 04/05 beq/bne SUB; any other opcode/funct SHALL decode as AND with RegWrite=0, MemRead=0.
REQ-028 Immediate SHALL be zero-extended for 0C/0D/0E, sign-extended otherwise.
REQ-029 Operands: R-type A=rs, B=rt; shifts A=rt, B={27'b0,shamt Instr[10:6]}; I-type A=rs, B=imm; LUI A=0, B=imm.
REQ-030 Destination SHALL be Instr[15:11] for R-type, Instr[20:16] for I-type; RegWrite=1 for R-type, ALU I-types, LUI and lw; 0 for sw, beq, bne.
REQ-031 Forwarding per register-sourced operand: if ExMemRegWrite & ExMemRd!=0 & match -> ExMemResult; else if MemWbRegWrite & MemWbRd!=0 & match -> MemWbData; else registered value; EX/MEM wins simultaneous matches.
REQ-032 Immediate and shamt operands SHALL never be forwarded.

Reset
REQ-033 ResetL low SHALL immediately clear all registers: OutValid=0, OutRegWrite=0, OutMemRead=0, OutRd=0, ALUCtrl=0000, stored operands=0; reset mid-Stall discards the held instruction.

Configuration
REQ-034 Macro ID_EX_FWD_EN defined: REQ-031 forwarding active; undefined: BusA/BusB SHALL be the registered operands directly and Ex*/MemWb* inputs ignored.

Structure
REQ-035 ALUCtrl codes, opcode and funct constants SHALL live in shared package alu_pkg; combinational decode SHALL be sub-module alu_decode (Instr -> ALUCtrl, imm, dest, RegWrite, MemRead, operand selects).

Verification
REQ-036 add $3,$1,$2 (Instr 00221820), RsData=5, RtData=7 -> next cycle BusA=5, BusB=7, ALUCtrl=0010, OutRd=3, OutRegWrite=1.
REQ-037 andi $4,$1,0xFFFF -> BusB=0000FFFF, ALUCtrl=0000; addi $4,$1,-1 -> BusB=FFFFFFFF, ALUCtrl=0010.
REQ-038 sll $2,$3,4 with RtData=1 -> BusA=1, BusB=4, ALUCtrl=0011; lui $5,0x1234 -> BusA=0, BusB=00001234, ALUCtrl=1110.
REQ-039 rs=$1 in EX, ExMemRd=1 with ExMemResult=AA, MemWbRd=1 with MemWbData=BB, both RegWrite=1 -> BusA=AA; ExMemRd=0 -> BusA=BB; macro undefined -> registered RsData.
REQ-040 Stall=1 and Flush=1 same edge -> OutValid=0; Stall only -> outputs unchanged for 3 cycles; ResetL low mid-Stall -> OutValid=0 asynchronously.
REQ-041 lw $8 in EX, ID holds add $9,$8,$1 -> LoadUseHazard=1; ID rs=$0 with OutRd=0 -> LoadUseHazard=0.
